// File: rtl/sram_1r1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_1r1w_ctrl
// Brief    : Parametrised 1R1W bit-masked buffer memory with read pipeline,
//            zero-clear sweep and sticky error flag.
// Revision : 1.0
// ============================================================================
module sram_1r1w_ctrl #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 16384,
    parameter  int READ_LAT = 1,
    parameter  int RDW_MODE = 0,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              CS,
    input  logic              WEB,
    input  logic              RE,
    input  logic [ADDR_W-1:0] R_ADDR,
    input  logic [ADDR_W-1:0] W_ADDR,
    input  logic [DATA_W-1:0] D_IN,
    input  logic [DATA_W-1:0] BWEB,
    output logic [DATA_W-1:0] D_OUT,
    output logic              R_VALID,
    input  logic              CLR,
    output logic              INIT_BUSY,
    output logic              ERR,
    input  logic              ERR_CLR
);

    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic                r_err;
    logic                r_valid;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_ready;
    logic                w_wr_req;
    logic                w_rd_req;
    logic                w_w_in;
    logic                w_r_in;
    logic                w_wr_en;
    logic                w_rd_acc;
    logic                w_err_set;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_pipe_v;
    logic [DATA_W-1:0]   w_pipe_d;

    assign w_ready   = (r_state == ST_READY);
    assign w_wr_req  = CS & ~WEB;
    assign w_rd_req  = CS & RE;
    assign w_w_in    = ({1'b0, W_ADDR} < c_depth);
    assign w_r_in    = ({1'b0, R_ADDR} < c_depth);
    assign w_wr_en   = w_ready & w_wr_req & w_w_in;
    assign w_rd_acc  = w_ready & w_rd_req;
    // Any access during a sweep, or any out-of-range access, raises the flag
    assign w_err_set = (~w_ready & (w_wr_req | w_rd_req))
                     | (w_ready & w_wr_req & ~w_w_in)
                     | (w_rd_acc & ~w_r_in);

    assign w_old    = r_mem[R_ADDR];
    assign w_merged = (w_old & BWEB) | (D_IN & ~BWEB);

    always_comb begin
        w_rd_data = '0;
        if (w_r_in) begin
            if (RDW_MODE == 1 && w_wr_en && (W_ADDR == R_ADDR)) begin
                w_rd_data = w_merged;
            end else begin
                w_rd_data = w_old;
            end
        end
    end

    // Array has no reset; the clear sweep zeroes it
    always_ff @(posedge CK) begin
        if (!w_ready) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[W_ADDR] <= (r_mem[W_ADDR] & BWEB) | (D_IN & ~BWEB);
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (CLR) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_v1;
            logic [DATA_W-1:0] r_d1;
            always_ff @(posedge CK or negedge RSTN) begin
                if (!RSTN) begin
                    r_v1 <= 1'b0;
                    r_d1 <= '0;
                end else begin
                    r_v1 <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_d1 <= w_rd_data;
                    end
                end
            end
            assign w_pipe_v = r_v1;
            assign w_pipe_d = r_d1;
        end else begin : g_lat1
            assign w_pipe_v = w_rd_acc;
            assign w_pipe_d = w_rd_data;
        end
    endgenerate

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= w_pipe_v;
            if (w_pipe_v) begin
                r_dout <= w_pipe_d;
            end
        end
    end

    assign D_OUT     = r_dout;
    assign R_VALID   = r_valid;
    assign INIT_BUSY = r_busy;
    assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1r1w_ctrl
// Brief    : Directed bench; drives two configurations with shared stimulus:
//            A = DEPTH 12 / READ_LAT 2 / RDW old, B = DEPTH 16 / READ_LAT 1 / RDW new.
// Revision : 1.0
// ============================================================================
module tb_sram_1r1w_ctrl;

    logic        ck = 1'b0;
    logic        rstn = 1'b1;
    logic        cs = 1'b0;
    logic        web = 1'b1;
    logic        re = 1'b0;
    logic        clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  r_addr = '0;
    logic [3:0]  w_addr = '0;
    logic [31:0] d_in = '0;
    logic [31:0] bweb = '1;

    logic [31:0] dout_a, dout_b;
    logic        rv_a, rv_b, busy_a, busy_b, err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ck = ~ck;

    sram_1r1w_ctrl #(.DATA_W(32), .DEPTH(12), .READ_LAT(2), .RDW_MODE(0)) u_dut_a (
        .CK(ck), .RSTN(rstn), .CS(cs), .WEB(web), .RE(re),
        .R_ADDR(r_addr), .W_ADDR(w_addr), .D_IN(d_in), .BWEB(bweb),
        .D_OUT(dout_a), .R_VALID(rv_a), .CLR(clr), .INIT_BUSY(busy_a),
        .ERR(err_a), .ERR_CLR(err_clr)
    );

    sram_1r1w_ctrl #(.DATA_W(32), .DEPTH(16), .READ_LAT(1), .RDW_MODE(1)) u_dut_b (
        .CK(ck), .RSTN(rstn), .CS(cs), .WEB(web), .RE(re),
        .R_ADDR(r_addr), .W_ADDR(w_addr), .D_IN(d_in), .BWEB(bweb),
        .D_OUT(dout_b), .R_VALID(rv_b), .CLR(clr), .INIT_BUSY(busy_b),
        .ERR(err_b), .ERR_CLR(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [31:0] m);
        cs = 1'b1; web = 1'b0; w_addr = a; d_in = d; bweb = m;
        tick;
        cs = 1'b0; web = 1'b1;
    endtask

    // B answers one edge after acceptance, A two edges after
    task automatic do_read(input string tag, input logic [3:0] a,
                           input logic [31:0] ea, input logic [31:0] eb);
        cs = 1'b1; re = 1'b1; r_addr = a;
        tick;
        cs = 1'b0; re = 1'b0;
        check({tag, "_vb1"}, rv_b, 1);
        check({tag, "_db"},  dout_b, eb);
        check({tag, "_va0"}, rv_a, 0);
        tick;
        check({tag, "_vb0"}, rv_b, 0);
        check({tag, "_va1"}, rv_a, 1);
        check({tag, "_da"},  dout_a, ea);
    endtask

    task automatic sweep_count(input string tag, input int ea, input int eb);
        int na = 0;
        int nb = 0;
        for (int n = 1; n <= 40 && (na == 0 || nb == 0); n++) begin
            tick;
            if (!busy_a && na == 0) na = n;
            if (!busy_b && nb == 0) nb = n;
        end
        check({tag, "_len_a"}, na, ea);
        check({tag, "_len_b"}, nb, eb);
    endtask

    initial begin
        #1 rstn = 1'b0;
        #1;
        check("rst_dout_a", dout_a, 0);
        check("rst_dout_b", dout_b, 0);
        check("rst_rv_a", rv_a, 0);
        check("rst_rv_b", rv_b, 0);
        check("rst_err_a", err_a, 0);
        check("rst_busy_a", busy_a, 1);
        check("rst_busy_b", busy_b, 1);
        tick;
        tick;
        rstn = 1'b1;
        sweep_count("sweep_rst", 12, 16);

        // Whole range reads zero; A sees 12..15 as out of range
        for (int i = 0; i < 16; i++) begin
            do_read("sweep_rd", 4'(i), 32'h0, 32'h0);
        end
        check("oor_rd_err_a", err_a, 1);
        check("oor_rd_err_b", err_b, 0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("errclr_a", err_a, 0);

        do_write(4'd3, 32'hFFFF_FFFF, 32'h0);
        do_write(4'd3, 32'h0000_0000, 32'hFFFF_0000);
        do_read("mask", 4'd3, 32'hFFFF_0000, 32'hFFFF_0000);

        for (int k = 0; k < 8; k++) begin
            do_write(4'(k), 32'(k * 32'h11), 32'h0);
        end
        for (int c = 0; c < 10; c++) begin
            cs = (c < 8); re = (c < 8); r_addr = 4'(c);
            tick;
            if (c < 8) begin
                check("strm_vb", rv_b, 1);
                check("strm_db", dout_b, 32'(c * 32'h11));
            end else begin
                check("strm_vb_end", rv_b, 0);
            end
            if (c >= 1 && c <= 8) begin
                check("strm_va", rv_a, 1);
                check("strm_da", dout_a, 32'((c - 1) * 32'h11));
            end else begin
                check("strm_va_idle", rv_a, 0);
            end
        end
        cs = 1'b0; re = 1'b0;

        do_write(4'd5, 32'hAAAA_AAAA, 32'h0);
        cs = 1'b1; re = 1'b1; web = 1'b0; r_addr = 4'd5; w_addr = 4'd5;
        d_in = 32'h5555_5555; bweb = 32'h0;
        tick;
        cs = 1'b0; re = 1'b0; web = 1'b1;
        check("rdw_vb", rv_b, 1);
        check("rdw_new_b", dout_b, 32'h5555_5555);
        tick;
        check("rdw_va", rv_a, 1);
        check("rdw_old_a", dout_a, 32'hAAAA_AAAA);
        do_read("rdw_after", 4'd5, 32'h5555_5555, 32'h5555_5555);

        // Independent read and write to different words in one cycle
        cs = 1'b1; re = 1'b1; web = 1'b0; r_addr = 4'd3; w_addr = 4'd6;
        d_in = 32'h1234_5678; bweb = 32'h0;
        tick;
        cs = 1'b0; re = 1'b0; web = 1'b1;
        check("rw_diff_db", dout_b, 32'h33);
        tick;
        check("rw_diff_da", dout_a, 32'h33);
        do_read("rw_diff_wr", 4'd6, 32'h1234_5678, 32'h1234_5678);

        do_write(4'd13, 32'hDEAD_BEEF, 32'h0);
        check("oor_wr_err_a", err_a, 1);
        check("oor_wr_err_b", err_b, 0);
        do_read("oor13", 4'd13, 32'h0, 32'hDEAD_BEEF);
        do_read("oor14", 4'd14, 32'h0, 32'h0);
        do_read("noalias", 4'd1, 32'h11, 32'h11);
        err_clr = 1'b1;
        do_write(4'd13, 32'h0, 32'h0);
        err_clr = 1'b0;
        check("set_wins_a", err_a, 1);
        check("set_wins_b", err_b, 0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("errclr2_a", err_a, 0);

        // CLR with a read accepted on the same edge
        cs = 1'b1; re = 1'b1; r_addr = 4'd5; clr = 1'b1;
        tick;
        cs = 1'b0; re = 1'b0; clr = 1'b0;
        check("clr_inflight_vb", rv_b, 1);
        check("clr_inflight_db", dout_b, 32'h5555_5555);
        check("clr_busy_a", busy_a, 1);
        check("clr_busy_b", busy_b, 1);
        tick;
        check("clr_inflight_va", rv_a, 1);
        check("clr_inflight_da", dout_a, 32'h5555_5555);
        cs = 1'b1; re = 1'b1; r_addr = 4'd2;
        tick;
        cs = 1'b0; re = 1'b0;
        check("clr_rd_err_a", err_a, 1);
        check("clr_rd_err_b", err_b, 1);
        check("clr_rd_nov_b", rv_b, 0);
        tick;
        check("clr_rd_nov_a", rv_a, 0);
        sweep_count("sweep_clr", 9, 13);
        do_read("after_clr", 4'd5, 32'h0, 32'h0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;

        // Asynchronous reset with reads in flight in both pipelines
        do_write(4'd5, 32'hCAFE_F00D, 32'h0);
        cs = 1'b1; re = 1'b1; r_addr = 4'd5;
        tick;
        cs = 1'b0; re = 1'b0;
        check("rst_inflight_vb", rv_b, 1);
        rstn = 1'b0;
        #1;
        check("rst_async_vb", rv_b, 0);
        check("rst_async_db", dout_b, 0);
        check("rst_async_busy", busy_b, 1);
        tick;
        check("rst_flush_va", rv_a, 0);
        rstn = 1'b1;
        sweep_count("sweep_rst2", 12, 16);

        // Reset at sweep cycle 7 restarts the full sweep
        do_write(4'd4, 32'h0BAD_CAFE, 32'h0);
        do_read("pre_clr", 4'd4, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        cs = 1'b1; re = 1'b1;
        tick;
        cs = 1'b0; re = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("mid_err_b", err_b, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_err_b", err_b, 0);
        check("mid_rst_dout_a", dout_a, 0);
        check("mid_rst_rv_a", rv_a, 0);
        check("mid_rst_busy_a", busy_a, 1);
        tick;
        rstn = 1'b1;
        sweep_count("sweep_mid", 12, 16);
        do_read("final", 4'd4, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
